// File: rtl/hex_display_counter_if.sv
// Board-facing pushbutton/switch inputs and HEX/LED outputs of the display counter.
interface hex_display_counter_if #(
  parameter int NUM_DIGITS = 6,
  parameter int SW_WIDTH   = 10,
  parameter int LED_WIDTH  = 10
);
  logic [2:0]              KEY;
  logic [SW_WIDTH-1:0]     SW;
  logic [7*NUM_DIGITS-1:0] HEX;
  logic [LED_WIDTH-1:0]    LEDR;

  modport master (output KEY, output SW, input HEX, input LEDR);
  modport slave  (input KEY, input SW, output HEX, output LEDR);
endinterface

// File: rtl/hex_display_counter.sv
// N-digit hex/BCD up/down counter driving 7-segment HEX and LEDR; KEY acts 3 cycles after its edge.
// Optional key debouncer enabled by HEX_DISPLAY_COUNTER_DEBOUNCE_EN (adds CLK_FREQ_HZ/1000 cycles).
module hex_display_counter #(
  parameter int NUM_DIGITS  = 6,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 10,
  parameter int SW_WIDTH    = 10,
  parameter int LED_WIDTH   = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  RESETn,
  hex_display_counter_if.slave  bus
);

  localparam int CW   = 4 * NUM_DIGITS;
  localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
  localparam int DIVW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int LDW  = SW_WIDTH - 2;
  localparam int LEXT = (LDW > CW) ? LDW : CW;
  localparam int LEDW = LED_WIDTH - 4;
  localparam int CEXT = (LEDW > CW) ? LEDW : CW;

  // ---------------- synchronisers ----------------
  logic [2:0]          r_key_s1, r_key_s2;
  logic [SW_WIDTH-1:0] r_sw_s1, r_sw_s2;
  logic [1:0]          r_sync_vld;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      r_key_s1   <= 3'b111;
      r_key_s2   <= 3'b111;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_sync_vld <= 2'b00;
    end else begin
      r_key_s1   <= bus.KEY;
      r_key_s2   <= r_key_s1;
      r_sw_s1    <= bus.SW;
      r_sw_s2    <= r_sw_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  logic w_dir_down, w_radix_bcd;
  assign w_dir_down  = r_sw_s2[SW_WIDTH-1];
  assign w_radix_bcd = r_sw_s2[SW_WIDTH-2];

  // ---------------- optional debouncer ----------------
  logic [2:0] w_key_lvl;

`ifdef HEX_DISPLAY_COUNTER_DEBOUNCE_EN
  localparam int DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0]     r_key_db;
  logic [DBW-1:0] r_db_cnt [3];

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      r_key_db <= 3'b111;
      for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (r_key_s2[k] == r_key_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_key_db[k] <= r_key_s2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DBW'(1);
        end
      end
    end
  end

  assign w_key_lvl = r_key_db;
`else
  assign w_key_lvl = r_key_s2;
`endif

  // ---------------- press detect ----------------
  // A key only arms once it has been seen released after reset, so keys held through reset are ignored.
  logic [2:0] r_key_prev, r_key_armed;
  logic [2:0] w_press;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      r_key_prev  <= 3'b111;
      r_key_armed <= 3'b000;
    end else begin
      r_key_prev  <= w_key_lvl;
      if (r_sync_vld[1]) r_key_armed <= r_key_armed | r_key_s2;
    end
  end

  assign w_press = r_key_armed & r_key_prev & ~w_key_lvl;

  logic w_run_press, w_load_press, w_clr_press;
  assign w_run_press  = w_press[0];
  assign w_load_press = w_press[1];
  assign w_clr_press  = w_press[2];

  // ---------------- tick divider ----------------
  logic [DIVW-1:0] r_div;
  logic            w_tick;

  assign w_tick = (r_div == DIVW'(DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn)     r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIVW'(1);
  end

  // ---------------- next-count logic ----------------
  logic [CW-1:0] r_count;
  logic          r_run, r_wrap, r_radix_prev;

  logic [CW-1:0] w_hex_next;
  logic          w_hex_wrap;

  assign w_hex_next = w_dir_down ? (r_count - CW'(1)) : (r_count + CW'(1));
  assign w_hex_wrap = w_dir_down ? (r_count == '0) : (r_count == '1);

  // Ripple carry/borrow through the decimal digits; a carry out of the top digit is a wrap.
  logic [CW-1:0] w_bcd_next;
  logic          w_bcd_c;
  logic          w_bcd_wrap;

  always_comb begin
    w_bcd_next = r_count;
    w_bcd_c    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_bcd_c) begin
        if (!w_dir_down) begin
          if (r_count[4*i +: 4] >= 4'd9) begin
            w_bcd_next[4*i +: 4] = 4'd0;
          end else begin
            w_bcd_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
            w_bcd_c              = 1'b0;
          end
        end else begin
          if (r_count[4*i +: 4] == 4'd0) begin
            w_bcd_next[4*i +: 4] = 4'd9;
          end else begin
            w_bcd_next[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
            w_bcd_c              = 1'b0;
          end
        end
      end
    end
    w_bcd_wrap = w_bcd_c;
  end

  // Load value: zero-extend/truncate the switch field, then clamp nibbles to 9 in BCD.
  logic [LEXT-1:0] w_ld_ext;
  logic [CW-1:0]   w_ld_val;

  assign w_ld_ext = LEXT'(r_sw_s2[LDW-1:0]);

  always_comb begin
    w_ld_val = w_ld_ext[CW-1:0];
    if (w_radix_bcd) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_ld_val[4*i +: 4] > 4'd9) w_ld_val[4*i +: 4] = 4'd9;
      end
    end
  end

  logic w_radix_chg;
  assign w_radix_chg = (w_radix_bcd != r_radix_prev);

  // ---------------- state registers ----------------
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      r_count      <= '0;
      r_run        <= 1'b0;
      r_wrap       <= 1'b0;
      r_radix_prev <= 1'b0;
    end else begin
      r_radix_prev <= w_radix_bcd;
      if (w_clr_press) begin
        r_count <= '0;
        r_run   <= 1'b0;
        r_wrap  <= 1'b0;
      end else begin
        if (w_run_press) r_run <= ~r_run;
        if (w_load_press) begin
          r_count <= w_ld_val;
          r_wrap  <= 1'b0;
        end else if (w_radix_chg) begin
          r_count <= '0;
          r_wrap  <= 1'b0;
        end else if (w_tick && r_run) begin
          r_count <= w_radix_bcd ? w_bcd_next : w_hex_next;
          if (w_radix_bcd ? w_bcd_wrap : w_hex_wrap) r_wrap <= 1'b1;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  logic [7*NUM_DIGITS-1:0] w_hex;

  always_comb begin
    w_hex = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_hex[7*i +: 7] = seg_decode(r_count[4*i +: 4]);
    end
  end

  logic [CEXT-1:0] w_count_ext;
  assign w_count_ext = CEXT'(r_count);

  assign bus.HEX  = w_hex;
  assign bus.LEDR = {w_count_ext[LEDW-1:0], w_radix_bcd, w_dir_down, r_wrap, r_run};

endmodule

// File: tb/tb_hex_display_counter.sv
// Directed self-checking bench for hex_display_counter (100 Hz clock, 10 Hz tick, 2 digits).
module tb_hex_display_counter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  hex_display_counter_if #(.NUM_DIGITS(2), .SW_WIDTH(10), .LED_WIDTH(10)) u_if ();

  hex_display_counter #(
    .NUM_DIGITS(2), .CLK_FREQ_HZ(100), .TICK_HZ(10), .SW_WIDTH(10), .LED_WIDTH(10)
  ) dut (
    .CLOCK_50 (clk),
    .RESETn   (rst_n),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] hexv(input logic [7:0] v);
    hexv = {seg(v[7:4]), seg(v[3:0])};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Keys are active-low; mask bits set to 1 are held down.
  task automatic key_down(input logic [2:0] mask);
    u_if.KEY = ~mask;
    step(3);
  endtask

  task automatic key_up();
    u_if.KEY = 3'b111;
    step(3);
  endtask

  task automatic wait_change(input logic [13:0] from);
    int n;
    n = 0;
    while (u_if.HEX == from && n < 20) begin
      step(1);
      n++;
    end
    chk("wait_tick", {31'b0, n < 20}, 32'd1);
  endtask

  initial begin
    n_chk   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    u_if.KEY = 3'b111;
    u_if.SW  = 10'd0;

    // Reset state
    step(3);
    chk("rst_hex", {18'b0, u_if.HEX}, 32'h2040);
    chk("rst_ledr", {22'b0, u_if.LEDR}, 32'h0);
    rst_n = 1'b1;
    step(50);
    chk("idle_hex", {18'b0, u_if.HEX}, 32'h2040);

    // Hex up count and wrap after 256 ticks
    key_down(3'b001);
    chk("run_on", {31'b0, u_if.LEDR[0]}, 32'd1);
    key_up();
    wait_change(hexv(8'h00));
    chk("hex_first", {18'b0, u_if.HEX}, {18'b0, hexv(8'h01)});
    wait_change(hexv(8'h01));
    chk("hex_second", {18'b0, u_if.HEX}, {18'b0, hexv(8'h02)});
    step(10 * 253);
    chk("hex_ff", {18'b0, u_if.HEX}, {18'b0, hexv(8'hFF)});
    chk("hex_ff_wrap", {31'b0, u_if.LEDR[1]}, 32'd0);
    chk("hex_ff_led", {26'b0, u_if.LEDR[9:4]}, 32'h3F);
    step(10);
    chk("hex_wrap_cnt", {18'b0, u_if.HEX}, {18'b0, hexv(8'h00)});
    chk("hex_wrap_flag", {31'b0, u_if.LEDR[1]}, 32'd1);

    // Hex down from 0 wraps to FF
    u_if.SW[9] = 1'b1;
    step(10);
    chk("hex_down", {18'b0, u_if.HEX}, {18'b0, hexv(8'hFF)});
    chk("dir_led", {31'b0, u_if.LEDR[2]}, 32'd1);

    // Clear while running
    key_down(3'b100);
    chk("clr_hex", {18'b0, u_if.HEX}, 32'h2040);
    chk("clr_runwrap", {30'b0, u_if.LEDR[1:0]}, 32'd0);
    key_up();

    // BCD down wrap, then up wrap and ripple carry
    u_if.SW[8] = 1'b1;
    step(4);
    chk("radix_led", {31'b0, u_if.LEDR[3]}, 32'd1);
    key_down(3'b001);
    key_up();
    wait_change(hexv(8'h00));
    chk("bcd_dn_wrap", {18'b0, u_if.HEX}, 32'h0810);
    chk("bcd_wrap_flag", {31'b0, u_if.LEDR[1]}, 32'd1);
    wait_change(hexv(8'h99));
    chk("bcd_98", {18'b0, u_if.HEX}, {18'b0, hexv(8'h98)});
    u_if.SW[9] = 1'b0;
    step(10);
    chk("bcd_99", {18'b0, u_if.HEX}, {18'b0, hexv(8'h99)});
    step(10);
    chk("bcd_up_wrap", {18'b0, u_if.HEX}, {18'b0, hexv(8'h00)});
    step(10);
    chk("bcd_01", {18'b0, u_if.HEX}, {18'b0, hexv(8'h01)});
    step(90);
    chk("bcd_carry", {18'b0, u_if.HEX}, {18'b0, hexv(8'h10)});

    // Load: BCD saturation, then hex radix
    key_down(3'b100);
    key_up();
    u_if.SW[7:0] = 8'hAB;
    step(2);
    key_down(3'b010);
    chk("ld_bcd_sat", {18'b0, u_if.HEX}, {18'b0, hexv(8'h99)});
    chk("ld_bcd_wrap", {31'b0, u_if.LEDR[1]}, 32'd0);
    key_up();
    u_if.SW[8] = 1'b0;
    step(4);
    chk("radix_zero", {18'b0, u_if.HEX}, 32'h2040);
    key_down(3'b010);
    chk("ld_hex", {18'b0, u_if.HEX}, {18'b0, hexv(8'hAB)});
    chk("ld_hex_led", {26'b0, u_if.LEDR[9:4]}, 32'h2B);
    key_up();

    // Clear beats load while running; radix change keeps count 0
    key_down(3'b001);
    key_up();
    step(25);
    key_down(3'b110);
    chk("prio_hex", {18'b0, u_if.HEX}, 32'h2040);
    chk("prio_run", {31'b0, u_if.LEDR[0]}, 32'd0);
    key_up();
    u_if.SW[8] = 1'b1;
    step(4);
    chk("prio_radix", {18'b0, u_if.HEX}, 32'h2040);
    chk("prio_wrap", {31'b0, u_if.LEDR[1]}, 32'd0);

    // Run toggle and load together both take effect
    u_if.SW[7:0] = 8'h12;
    step(2);
    key_down(3'b011);
    chk("ldrun_hex", {18'b0, u_if.HEX}, {18'b0, hexv(8'h12)});
    chk("ldrun_run", {31'b0, u_if.LEDR[0]}, 32'd1);
    key_up();

    // Reset mid-run with a key held through it
    u_if.KEY = 3'b110;
    step(1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_hex", {18'b0, u_if.HEX}, 32'h2040);
    chk("mid_rst_ledr", {22'b0, u_if.LEDR[3:0]}, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("held_key", {31'b0, u_if.LEDR[0]}, 32'd0);
    key_up();
    key_down(3'b001);
    chk("repress", {31'b0, u_if.LEDR[0]}, 32'd1);
    key_up();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
